router_out_reader: RTL and testbench
====================================

Name: router_out_reader

Overview:
- Read-side controller for one router output port.
- Drains the port FIFO through its read_enb/empty/data_out interface, and holds each byte in an output register with a valid/read handshake toward the destination client.
- Tracks packet framing from the header byte: header[7:2] is the payload length and one parity byte closes each packet.
- Fires a one-cycle soft reset to the FIFO when the client stalls for too long.

Parameters:
- TIMEOUT_CYC, 30: consecutive stalled cycles (vld_out=1, read_in=0) that trigger a timeout drop.
- TMO_W, 5: width of the timeout counter. Must satisfy 2**TMO_W >= TIMEOUT_CYC.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO read data; valid in the cycle after fifo_rd_en was sampled high.
- fifo_rd_en  out  1  FIFO read enable (combinational from state and inputs).
- fifo_soft_reset  out  1  registered one-cycle pulse on timeout.
- read_in  in  1  client accepts the byte on data_out this cycle.
- vld_out  out  1  data_out holds a valid byte.
- data_out  out  8  held byte.
- sop_out  out  1  held byte is a packet header.
- eop_out  out  1  held byte is a parity (last) byte.
- parity_err  out  1  parity mismatch, valid when vld_out and eop_out are both high.

Behaviour:
- Reset (resetn=0 at an edge): state=IDLE; vld_out, sop_out, eop_out, parity_err, fifo_soft_reset=0; data_out=8'h00; remaining=0; next_is_header=1; timeout counter=0. fifo_rd_en is forced 0 combinationally while resetn=0.
- State machine:
  - IDLE: fifo_rd_en = !fifo_empty. If fifo_rd_en=1, go to WAIT.
  - WAIT: fifo_rd_en=0. At the edge, capture fifo_data into data_out, set vld_out=1, go to HOLD.
  - HOLD: vld_out=1. A transfer occurs when read_in=1.
    - On transfer: fifo_rd_en = !fifo_empty that same cycle. If fetching, go to WAIT; otherwise go to IDLE. vld_out clears at the edge unless a new capture happens later in WAIT.
    - No transfer: data_out, sop_out, eop_out and parity_err hold stable.
  - DROP: one cycle. fifo_soft_reset=1, fifo_rd_en=0. Then go to IDLE.
- Latency and throughput: fifo_rd_en high in cycle N means vld_out=1 from edge N+2 onward. Peak throughput is 1 byte per 2 cycles.
- Framing, updated at the capture edge:
  - next_is_header=1: sop_out=1, eop_out=0, remaining <= fifo_data[7:2]+1 (7-bit result), next_is_header <= 0.
  - next_is_header=0: sop_out=0, eop_out=(remaining==1), remaining <= remaining-1. When eop_out is set, next_is_header <= 1.
  - A header with length 0 is followed directly by the parity byte. Maximum packet size is 63 payload bytes plus header and parity.
- Address bits header[1:0] are passed through untouched; they are not interpreted here.
- Timeout:
  - The counter increments each HOLD cycle with read_in=0 and clears on a transfer or on leaving HOLD.
  - When the counter equals TIMEOUT_CYC-1 and read_in=0, the next state is DROP.
  - DROP clears vld_out, sop_out, eop_out, parity_err and the counter, and sets next_is_header=1 and remaining=0.
  - If read_in=1 in the same cycle the threshold is reached, the transfer wins and there is no drop.
- Resetn low in any state, including WAIT or DROP, returns every register to its reset value at that edge. A byte in flight from the FIFO is discarded.

Optional Feature:
- Macro OUT_PARITY_CHK_EN.
- Defined:
  - An 8-bit running XOR acc is loaded with the header at header capture, and XORed with each payload byte at its capture.
  - At parity-byte capture, parity_err <= (acc != fifo_data).
  - parity_err clears at the next capture, in DROP, and on reset.
- Not defined: parity_err is tied to 0 and no accumulator is built.

Test Plan:
- Back-to-back packet: FIFO holds 0x0D,0x11,0x22,0x33,0x0D with read_in held 1 -> client sees the bytes in order, one every 2 cycles. sop_out=1 on 0x0D (first), eop_out=1 on the final 0x0D, parity_err=0 with the feature on; fifo_rd_en pulses 5 times.
- Zero-length packet 0x02 then parity 0x02 -> sop on the first byte, eop on the second, parity_err=0. Next FIFO byte is treated as a header (sop_out=1).
- Client stall: read_in=0 for 10 cycles mid-payload, then 1 -> data_out stable for all 10 cycles, no fifo_soft_reset, and the packet completes normally.
- Timeout: vld_out=1 with read_in=0 for 30 cycles -> fifo_soft_reset=1 for exactly one cycle, vld_out=0 the cycle after. The next FIFO byte gets sop_out=1.
- Parity error (feature on): send 0x0D,0x11,0x22,0x33,0x0C -> parity_err=1 with eop_out=1; the next packet's header shows parity_err=0.
- Reset in WAIT: drive resetn=0 one cycle after fifo_rd_en -> vld_out stays 0, data_out=0x00, and no byte is delivered for that read.

Source files
------------

// File: rtl/router_out_reader.sv
// rtl/router_out_reader.sv - read-side controller for one router output port (FIFO drain, client handshake, framing, timeout)
// Optional OUT_PARITY_CHK_EN builds a per-packet running-XOR parity check driving parity_err.
module router_out_reader #(
  parameter int TIMEOUT_CYC = 30,
  parameter int TMO_W       = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       fifo_soft_reset,
  input  logic       read_in,
  output logic       vld_out,
  output logic [7:0] data_out,
  output logic       sop_out,
  output logic       eop_out,
  output logic       parity_err
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [6:0]       remaining;
  logic             next_is_header;
  logic [TMO_W-1:0] tmo_cnt;
  logic             last_byte;

  assign last_byte = (remaining == 7'd1);

  always_comb begin
    fifo_rd_en = 1'b0;
    if (resetn) begin
      case (state)
        IDLE:    fifo_rd_en = !fifo_empty;
        HOLD:    fifo_rd_en = read_in && !fifo_empty;
        default: fifo_rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= IDLE;
      vld_out         <= 1'b0;
      sop_out         <= 1'b0;
      eop_out         <= 1'b0;
      fifo_soft_reset <= 1'b0;
      data_out        <= 8'h00;
      remaining       <= 7'd0;
      next_is_header  <= 1'b1;
      tmo_cnt         <= '0;
    end else begin
      fifo_soft_reset <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (fifo_rd_en) state <= WAIT;
        end
        WAIT: begin
          data_out <= fifo_data;
          vld_out  <= 1'b1;
          tmo_cnt  <= '0;
          state    <= HOLD;
          if (next_is_header) begin
            sop_out        <= 1'b1;
            eop_out        <= 1'b0;
            remaining      <= {1'b0, fifo_data[7:2]} + 7'd1;
            next_is_header <= 1'b0;
          end else begin
            sop_out   <= 1'b0;
            eop_out   <= last_byte;
            remaining <= remaining - 7'd1;
            if (last_byte) next_is_header <= 1'b1;
          end
        end
        HOLD: begin
          // A transfer in the threshold cycle beats the timeout.
          if (read_in) begin
            vld_out <= 1'b0;
            tmo_cnt <= '0;
            state   <= fifo_rd_en ? WAIT : IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt         <= '0;
            fifo_soft_reset <= 1'b1;
            state           <= DROP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DROP: begin
          vld_out        <= 1'b0;
          sop_out        <= 1'b0;
          eop_out        <= 1'b0;
          tmo_cnt        <= '0;
          next_is_header <= 1'b1;
          remaining      <= 7'd0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUT_PARITY_CHK_EN
  logic [7:0] acc;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc        <= 8'h00;
      parity_err <= 1'b0;
    end else if (state == WAIT) begin
      if (next_is_header) begin
        acc        <= fifo_data;
        parity_err <= 1'b0;
      end else if (last_byte) begin
        parity_err <= (acc != fifo_data);
      end else begin
        acc        <= acc ^ fifo_data;
        parity_err <= 1'b0;
      end
    end else if (state == DROP) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_reader.sv
// tb/tb_router_out_reader.sv - self-checking bench for router_out_reader (table vectors, corner sequences, random packets)
module tb_router_out_reader;

`ifdef OUT_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       fifo_soft_reset;
  logic       read_in;
  logic       vld_out;
  logic [7:0] data_out;
  logic       sop_out;
  logic       eop_out;
  logic       parity_err;

  always #5 clock = ~clock;

  router_out_reader #(.TIMEOUT_CYC(30), .TMO_W(5)) dut (
    .clock(clock), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .fifo_soft_reset(fifo_soft_reset), .read_in(read_in),
    .vld_out(vld_out), .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out),
    .parity_err(parity_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // FIFO model: read data appears the cycle after rd_en, soft reset flushes it.
  logic [7:0] fmem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clock) begin
    if (fifo_soft_reset) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_data <= fmem[rd_ptr[11:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic fpush(input logic [7:0] b);
    fmem[wr_ptr[11:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       perr;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic [7:0] d, input logic s, input logic e, input logic p);
    exp_t x;
    x.data = d; x.sop = s; x.eop = e; x.perr = p;
    exp_q.push_back(x);
  endtask

  // Packet-level reference: header {len,addr}, payload, XOR parity (optionally corrupted).
  task automatic send_pkt(input int len, input logic [1:0] addr, input bit corrupt);
    logic [7:0] h, b, par;
    h = {6'(len), addr};
    fpush(h); push_exp(h, 1'b1, 1'b0, 1'b0);
    par = h;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      fpush(b); push_exp(b, 1'b0, 1'b0, 1'b0);
      par = par ^ b;
    end
    if (corrupt) par = par ^ 8'(1 << $urandom_range(0, 7));
    fpush(par); push_exp(par, 1'b0, 1'b1, corrupt && PCHK);
  endtask

  typedef struct {
    logic [4:0][7:0] b;
    int              n;
    logic            perr;
  } vec_t;
  vec_t vt [4];

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, input int n, input logic perr);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    v.n = n; v.perr = perr;
    return v;
  endfunction

  task automatic push_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      fpush(v.b[i]);
      push_exp(v.b[i], i == 0, i == v.n - 1, (i == v.n - 1) && v.perr && PCHK);
    end
  endtask

  // Monitor / scoreboard on the client side.
  int   cyc = 0;
  int   rd_cnt = 0;
  int   soft_cnt = 0;
  int   last_xfer = 0;
  bit   mon_en = 0;
  exp_t me;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (fifo_rd_en) rd_cnt = rd_cnt + 1;
    if (fifo_soft_reset) soft_cnt = soft_cnt + 1;
    if (mon_en && vld_out && read_in) begin
      last_xfer = cyc;
      if (exp_q.size() == 0) check("unexpected_byte", 32'(data_out), 32'hFFFF_FFFF);
      else begin
        me = exp_q.pop_front();
        check("data", 32'(data_out), 32'(me.data));
        check("sop", 32'(sop_out), 32'(me.sop));
        check("eop", 32'(eop_out), 32'(me.eop));
        if (me.eop) check("parity_err_eop", 32'(parity_err), 32'(me.perr));
        if (me.sop) check("parity_err_sop", 32'(parity_err), 32'(0));
      end
    end
  end

  task automatic wait_drain(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !vld_out) begin
        ok = 1;
        break;
      end
    end
    check(name, 32'(ok), 32'(1));
  endtask

  task automatic wait_vld(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (vld_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check(name, 32'(0), 32'(1));
  endtask

  int c_rd, c_vld, r0, s0, n_stall, stall;
  bit found;

  initial begin
    resetn  = 1'b0;
    read_in = 1'b0;
    vt[0] = mk(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 5, 1'b0);
    vt[1] = mk(8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 2, 1'b0);
    vt[2] = mk(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C, 5, 1'b1);
    vt[3] = mk(8'h05, 8'hAA, 8'hAF, 8'h00, 8'h00, 3, 1'b0);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_vld", 32'(vld_out), 32'(0));
    check("rst_data", 32'(data_out), 32'(0));
    check("rst_sop", 32'(sop_out), 32'(0));
    check("rst_eop", 32'(eop_out), 32'(0));
    check("rst_perr", 32'(parity_err), 32'(0));
    check("rst_soft", 32'(fifo_soft_reset), 32'(0));
    check("rst_rd_en", 32'(fifo_rd_en), 32'(0));
    @(posedge clock); #1;
    resetn  = 1'b1;
    read_in = 1'b1;
    mon_en  = 1;

    // Table vectors with read_in held high: latency, throughput, read count.
    for (int v = 0; v < 4; v++) begin
      @(posedge clock); #1;
      r0 = rd_cnt;
      push_vec(vt[v]);
      found = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        if (fifo_rd_en) begin found = 1; break; end
      end
      c_rd = cyc;
      check("rd_en_seen", 32'(found), 32'(1));
      found = 0;
      for (int i = 0; i < 10; i++) begin
        if (vld_out) begin found = 1; break; end
        @(negedge clock);
      end
      c_vld = cyc;
      check("latency", 32'(c_vld - c_rd), 32'(2));
      wait_drain(60, "vec_drain");
      check("rd_pulses", 32'(rd_cnt - r0), 32'(vt[v].n));
      check("throughput", 32'(last_xfer - c_rd), 32'(2 * vt[v].n));
    end

    // Reset while WAIT: the in-flight byte is discarded.
    @(posedge clock); #1;
    fpush(8'h0D); fpush(8'h02); fpush(8'h02);
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("rstw_rd_en", 32'(fifo_rd_en), 32'(0));
    check("rstw_vld", 32'(vld_out), 32'(0));
    check("rstw_data", 32'(data_out), 32'(0));
    @(posedge clock); #1;
    resetn = 1'b1;
    push_exp(8'h02, 1'b1, 1'b0, 1'b0);
    push_exp(8'h02, 1'b0, 1'b1, 1'b0);
    wait_drain(30, "rstw_drain");

    // Client stall of 10 cycles on the second payload byte.
    @(posedge clock); #1;
    read_in = 1'b0;
    s0 = soft_cnt;
    push_vec(vt[0]);
    for (int k = 0; k < 5; k++) begin
      wait_vld("stall_vld");
      if (k == 2) begin
        for (int s = 0; s < 9; s++) begin
          @(negedge clock);
          check("stall_data", 32'(data_out), 32'h22);
          check("stall_vld_hold", 32'(vld_out), 32'(1));
        end
      end
      @(posedge clock); #1;
      read_in = 1'b1;
      @(negedge clock);
      @(posedge clock); #1;
      read_in = 1'b0;
    end
    wait_drain(30, "stall_drain");
    check("stall_no_soft", 32'(soft_cnt - s0), 32'(0));

    // Timeout: 30 stalled cycles then a single soft-reset pulse.
    s0 = soft_cnt;
    fpush(8'h0D); fpush(8'h11);
    wait_vld("tmo_vld");
    n_stall = 1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (fifo_soft_reset) begin found = 1; break; end
      if (vld_out) n_stall++;
    end
    check("tmo_fired", 32'(found), 32'(1));
    check("tmo_stall_cycles", 32'(n_stall), 32'(30));
    @(negedge clock);
    check("tmo_pulse_len", 32'(fifo_soft_reset), 32'(0));
    check("tmo_vld_after", 32'(vld_out), 32'(0));
    check("tmo_pulse_cnt", 32'(soft_cnt - s0), 32'(1));
    @(posedge clock); #1;
    read_in = 1'b1;
    push_vec(vt[1]);
    wait_drain(30, "tmo_next_pkt");

    // Randomised packets with random (bounded) client stalls.
    for (int p = 0; p < 25; p++)
      send_pkt($urandom_range(0, 12), 2'($urandom), ($urandom % 4) == 0);
    stall = 0;
    found = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clock); #1;
      read_in = (($urandom % 3) != 0) || (stall >= 15);
      if (vld_out && !read_in) stall++;
      else stall = 0;
      if (exp_q.size() == 0 && !vld_out) begin found = 1; break; end
    end
    check("random_drain", 32'(found), 32'(1));
    check("random_exp_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
